instr_encoder_loader: RTL

//  Inverse of the instruction decoder: takes decoded micro-op descriptors over a valid/ready port,

---
 rtl/instr_encoder_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Packs decoded micro-op descriptors into 32-bit machine words and streams them into IMEM
// at consecutive word addresses. Illegal descriptors are consumed, dropped and flagged.
module instr_encoder_loader #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [1:0]    in_class,
  input  logic [1:0]    in_cmd,
  input  logic          in_imm_sel,
  input  logic          in_s,
  input  logic [3:0]    in_cond,
  input  logic [3:0]    in_rd,
  input  logic [3:0]    in_rn,
  input  logic [3:0]    in_rm,
  input  logic [23:0]   in_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   word_count,
  output logic          err,
  output logic          done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [AW:0]   COUNT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   COUNT_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state;
  logic [AW-1:0] next_addr;
  logic [3:0]    dp_code;
  logic [31:0]   enc_word;
  logic          legal;

  assign in_ready = (state == RUN);
  assign legal    = (in_class != 2'b11);

  // ALU command to data-processing opcode field
  always_comb begin
    dp_code = 4'b0100;
    case (in_cmd)
      2'b00:   dp_code = 4'b0100;
      2'b01:   dp_code = 4'b0010;
      2'b10:   dp_code = 4'b0001;
      2'b11:   dp_code = 4'b1100;
      default: dp_code = 4'b0100;
    endcase
  end

  // Descriptor to machine word; register operand occupies the low nibble of operand2
  always_comb begin
    enc_word = 32'd0;
    case (in_class)
      2'b00: begin
        if (in_imm_sel) begin
          enc_word = {in_cond, 2'b00, 1'b1, dp_code, in_s, in_rn, in_rd, in_imm[11:0]};
        end else begin
          enc_word = {in_cond, 2'b00, 1'b0, dp_code, in_s, in_rn, in_rd, 8'd0, in_rm};
        end
      end
      2'b01: begin
        if (in_cmd[0]) begin
          enc_word = {in_cond, 2'b01, 6'b111101, in_rn, in_rd, 8'd0, in_rm};
        end else begin
          enc_word = {in_cond, 2'b01, 6'b001011, in_rn, in_rd, in_imm[11:0]};
        end
      end
      2'b10:   enc_word = {in_cond, 4'b1010, in_imm};
      default: enc_word = 32'd0;
    endcase
  end

  // Session FSM with registered IMEM write port and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      next_addr  <= {AW{1'b0}};
      imem_we    <= 1'b0;
      imem_addr  <= {AW{1'b0}};
      imem_wdata <= 32'd0;
      word_count <= {(AW+1){1'b0}};
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            next_addr  <= base_addr;
            word_count <= {(AW+1){1'b0}};
            err        <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= next_addr;
              imem_wdata <= enc_word;
              next_addr  <= next_addr + ADDR_ONE;
              if (word_count != COUNT_MAX) begin
                word_count <= word_count + COUNT_ONE;
              end else begin
                word_count <= word_count;
              end
            end else begin
              err <= 1'b1;
            end
            if (in_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
